// File: rtl/cayde_lsu.sv
// Single-outstanding load/store unit: accepts one op from execute, issues one
// data-memory request, zero-extends the load result. Option: CAYDE_LSU_MISALIGN_TRAP_EN.
module cayde_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_ld_op,
  input  logic [1:0]        req_st_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]  state;
  logic        is_store;
  logic [1:0]  op_q;
  logic [1:0]  lane_q;
  logic [4:0]  rd_q;

  logic [1:0]  code;
  logic        reject;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] shifted;
  logic [31:0] ld_data;

  assign req_ready = (state == IDLE);

  always_comb begin
    code    = req_store ? req_st_op : req_ld_op;
    reject  = (code == 2'd3);
`ifdef CAYDE_LSU_MISALIGN_TRAP_EN
    if ((code == 2'd1 && req_addr[0]) || (code == 2'd2 && req_addr[1:0] != 2'b00))
      reject = 1'b1;
`endif
    be_n    = 4'b1111;
    wdata_n = '0;
    if (req_store) begin
      case (req_st_op)
        2'd0: begin
          be_n    = 4'b0001 << req_addr[1:0];
          wdata_n = {4{req_wdata[7:0]}};
        end
        // Halfword lane comes from addr[1] only, so an odd address cannot
        // shift the enables off the top of the word.
        2'd1: begin
          be_n    = req_addr[1] ? 4'b1100 : 4'b0011;
          wdata_n = {2{req_wdata[15:0]}};
        end
        default: begin
          be_n    = 4'b1111;
          wdata_n = req_wdata;
        end
      endcase
    end
  end

  always_comb begin
    shifted = mem_rdata >> {lane_q, 3'b000};
    case (op_q)
      2'd0:    ld_data = {24'h0, shifted[7:0]};
      2'd1:    ld_data = lane_q[1] ? {16'h0, mem_rdata[31:16]} : {16'h0, mem_rdata[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      is_store  <= 1'b0;
      op_q      <= '0;
      lane_q    <= '0;
      rd_q      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      err       <= 1'b0;
    end else begin
      err      <= 1'b0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (reject) begin
              err <= 1'b1;
            end else begin
              is_store  <= req_store;
              op_q      <= code;
              lane_q    <= req_addr[1:0];
              rd_q      <= req_rd;
              mem_req   <= 1'b1;
              mem_we    <= req_store;
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_be    <= be_n;
              mem_wdata <= wdata_n;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            state     <= is_store ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_data  <= ld_data;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cayde_lsu.md
CAYDE_LSU -- requirements
Module: cayde_lsu

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the width of the byte address on the request and memory ports.
REQ-002 The port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 The port rst, input, 1 bit, SHALL be the reset, which is asynchronous and active-high.
REQ-004 The port req_valid, input, 1 bit, SHALL indicate that the execute stage presents a memory operation.
REQ-005 The port req_ready, output, 1 bit, SHALL indicate that the LSU accepts a request this cycle.
REQ-006 The port req_store, input, 1 bit, SHALL select a store (1) or a load (0).
REQ-007 The port req_ld_op, input, 2 bits, SHALL carry the load_op code: 0 = LBU, 1 = LHU, 2 = LW, 3 = reserved.
REQ-008 The port req_st_op, input, 2 bits, SHALL carry the store_op code: 0 = SB, 1 = SH, 2 = SW, 3 = reserved.
REQ-009 The ports req_addr (input, ADDR_W), req_wdata (input, 32) and req_rd (input, 5) SHALL carry the byte address, the store data and the load destination register.
REQ-010 The ports mem_req, mem_we (outputs, 1), mem_addr (output, ADDR_W), mem_be (output, 4) and mem_wdata (output, 32) SHALL form the data-memory request.
REQ-011 The ports mem_gnt, mem_rvalid (inputs, 1) and mem_rdata (input, 32) SHALL form the data-memory grant and read response.
REQ-012 The ports wb_valid (output, 1), wb_rd (output, 5) and wb_data (output, 32) SHALL form the load writeback.
REQ-013 The port err, output, 1 bit, SHALL pulse for one cycle when a request is rejected.

Function
REQ-014 The FSM SHALL have the states IDLE, REQ and WAIT; req_ready SHALL be 1 only in IDLE.
REQ-015 On accept (req_valid && req_ready) the LSU SHALL latch the op, the address, the data and rd, and enter REQ on the next cycle.
REQ-016 A reserved op code SHALL cause err=1 on the cycle after accept, no memory access, and a stay in IDLE.
REQ-017 In REQ, mem_req=1, and mem_addr SHALL equal the latched address with bits [1:0] = 0; all request outputs SHALL stay stable until mem_gnt.
REQ-018 For stores, mem_we=1, mem_be SHALL be 0001, 0011 or 1111 shifted left by addr[1:0], and mem_wdata SHALL be the data replicated into the selected lanes.
REQ-019 For loads, mem_we=0 and mem_be=1111.
REQ-020 On mem_gnt in REQ, a store SHALL return to IDLE and a load SHALL enter WAIT.
REQ-021 mem_rvalid outside WAIT SHALL be ignored.
REQ-022 On mem_rvalid in WAIT, the LSU SHALL return to IDLE, and on the next cycle wb_valid=1 for exactly one cycle with wb_rd = latched rd.
REQ-023 wb_data SHALL be the byte or halfword selected by addr[1:0], zero-extended, or the full word for LW.
REQ-024 wb_valid, err and mem_req SHALL be registered outputs; outputs SHALL be 0 whenever they are not valid.
REQ-025 Minimum latency SHALL be: accept at cycle N, mem_req at N+1, and, with gnt at N+1 and rvalid at N+2, wb_valid at N+3.

Reset
REQ-026 While rst=1, the state SHALL be IDLE and every output SHALL be 0 except req_ready; req_ready SHALL be 1 once rst deasserts.
REQ-027 A reset during REQ or WAIT SHALL abandon the operation; a later mem_rvalid SHALL produce no writeback.

Configuration
REQ-028 With CAYDE_LSU_MISALIGN_TRAP_EN defined, a misaligned request (LHU or SH with addr[0]=1, or LW or SW with addr[1:0]!=0) SHALL be rejected as in REQ-016.
REQ-029 Without CAYDE_LSU_MISALIGN_TRAP_EN, misalignment SHALL not be checked: a halfword SHALL use addr[1] and a word SHALL use the aligned word, and err SHALL pulse only for reserved codes.

Verification
REQ-030 LBU addr 0x1003, mem_rdata 0xAABBCCDD -> mem_addr 0x1000, mem_be 0xF, wb_data 0x000000AA.
REQ-031 SH addr 0x2002, wdata 0x12345678 -> mem_we 1, mem_be 0xC, mem_wdata 0x56785678 with lanes [3:2]=0x5678.
REQ-032 LW addr 0x3002 -> with the macro: err pulse and no mem_req; without it: mem_addr 0x3000, mem_be 0xF.
REQ-033 mem_gnt held low for 3 cycles -> mem_req, mem_addr and mem_be stable, req_ready 0 throughout.
REQ-034 rst pulse in WAIT, then mem_rvalid -> state IDLE, wb_valid stays 0, req_ready 1.
REQ-035 req_ld_op=3 -> err high for one cycle, mem_req stays 0, next request accepted.
